// File: rtl/agu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : agu_seq_if
// Brief    : Job-control, address-stream and AGU-control signals of agu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface agu_seq_if #(
    parameter int BWREPS  = 8,
    parameter int BWBEATS = 32
);
    logic               start;
    logic               start_ready;
    logic [BWREPS-1:0]  reps;
    logic               addr_valid;
    logic               addr_ready;
    logic               addr_last;
    logic               agu_clr;
    logic               agu_step;
    logic               agu_on_j4;
    logic               done;
    logic [BWBEATS-1:0] beat_cnt;

    // master: the sequencer itself
    modport master (
        input  start, reps, addr_ready, agu_on_j4,
        output start_ready, addr_valid, addr_last, agu_clr, agu_step, done, beat_cnt
    );

    // slave: control unit, downstream consumer and AGU seen as one environment
    modport slave (
        output start, reps, addr_ready, agu_on_j4,
        input  start_ready, addr_valid, addr_last, agu_clr, agu_step, done, beat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/agu_seq.sv
`default_nettype none
// ============================================================================
// Module   : agu_seq
// Brief    : Drives AGU clr/step and turns its address into a valid/ready
//            stream of (reps+1) full passes. Optional abort: AGU_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module agu_seq #(
    parameter int BWREPS  = 8,
    parameter int BWBEATS = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
`ifdef AGU_SEQ_ABORT_EN
    input  wire logic  abort,
`endif
    agu_seq_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BWREPS-1:0]  r_rep_cnt;
    logic [BWBEATS-1:0] r_beat_cnt;

    logic w_abort;
    logic w_start_ready;
    logic w_agu_clr;
    logic w_addr_valid;
    logic w_agu_step;
    logic w_addr_last;
    logic w_final_pass;

`ifdef AGU_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_final_pass = (r_rep_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_ready = 1'b0;
        w_agu_clr     = 1'b0;
        w_addr_valid  = 1'b0;
        w_agu_step    = 1'b0;
        w_addr_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_ready = 1'b1;
                if (bus.start) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                w_agu_clr = 1'b1;
                w_next    = w_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                w_addr_valid = 1'b1;
                // An aborted cycle must not advance the AGU or count a beat.
                w_agu_step   = bus.addr_ready & ~w_abort;
                w_addr_last  = w_agu_step & bus.agu_on_j4 & w_final_pass;
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_addr_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_rep_cnt  <= bus.reps;
            r_beat_cnt <= '0;
        end else if (w_agu_step) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            // The AGU wraps its own loops at a pass boundary; only the pass count moves here.
            if (bus.agu_on_j4 && !w_final_pass) begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
            end
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.agu_clr     = w_agu_clr;
    assign bus.addr_valid  = w_addr_valid;
    assign bus.agu_step    = w_agu_step;
    assign bus.addr_last   = w_addr_last;
    assign bus.done        = (r_state == S_DONE);
    assign bus.beat_cnt    = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_agu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_agu_seq
// Brief    : Directed bench for agu_seq with a behavioural 4-level AGU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agu_seq;

    logic clk;
    logic rst;
`ifdef AGU_SEQ_ABORT_EN
    logic abort;
`endif

    int vectors;
    int miscompares;

    agu_seq_if #(.BWREPS(8), .BWBEATS(32)) bus ();

    agu_seq #(.BWREPS(8), .BWBEATS(32)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AGU_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural AGU ----------------
    int          len [4];
    int          strd[5];
    int          idx [4];
    int          nxt_idx[4];
    logic [15:0] agu_addr;
    logic [15:0] nxt_addr;
    logic        carry;

    always_comb begin
        nxt_addr = agu_addr;
        carry    = 1'b1;
        for (int k = 0; k < 4; k++) nxt_idx[k] = idx[k];
        for (int k = 0; k < 4; k++) begin
            if (carry) begin
                if (idx[k] < len[k]) begin
                    nxt_idx[k] = idx[k] + 1;
                    nxt_addr   = agu_addr + 16'(strd[k]);
                    carry      = 1'b0;
                end else begin
                    nxt_idx[k] = 0;
                end
            end
        end
        if (carry) nxt_addr = agu_addr + 16'(strd[4]);
    end

    always @(posedge clk) begin
        if (bus.agu_clr) begin
            agu_addr <= 16'd0;
            for (int k = 0; k < 4; k++) idx[k] <= 0;
        end else if (bus.agu_step) begin
            agu_addr <= nxt_addr;
            for (int k = 0; k < 4; k++) idx[k] <= nxt_idx[k];
        end
    end

    assign bus.agu_on_j4 = bus.agu_step && (idx[0] == len[0]) && (idx[1] == len[1])
                           && (idx[2] == len[2]) && (idx[3] == len[3]);

    // ---------------- cumulative event monitor ----------------
    int tot_beats, tot_j4, tot_last, tot_done, tot_clr, last_at;

    initial begin
        tot_beats = 0; tot_j4 = 0; tot_last = 0; tot_done = 0; tot_clr = 0; last_at = 0;
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.addr_valid && bus.addr_ready) tot_beats = tot_beats + 1;
            if (bus.agu_on_j4) tot_j4 = tot_j4 + 1;
            if (bus.addr_valid && bus.addr_ready && bus.addr_last) begin
                tot_last = tot_last + 1;
                last_at  = tot_beats;
            end
            if (bus.done) tot_done = tot_done + 1;
            if (bus.agu_clr) tot_clr = tot_clr + 1;
        end
    end

    task automatic set_lengths(input int l0, input int l1, input int j0, input int j4);
        len[0] = l0; len[1] = l1; len[2] = 0; len[3] = 0;
        strd[0] = j0; strd[1] = 7; strd[2] = 11; strd[3] = 13; strd[4] = j4;
    endtask

    // Waits for done from the current negedge; cycles counts negedges waited.
    task automatic wait_done(input int budget, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clk); #1;
            cycles++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        @(negedge clk); #1;
        vectors++;
        if (bus.start_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.agu_clr !== 1'b0 ||
            bus.agu_step !== 1'b0 || bus.done !== 1'b0 || bus.beat_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b clr=%b step=%b done=%b cnt=%0d, want 1 0 0 0 0 0",
                     bus.start_ready, bus.addr_valid, bus.agu_clr, bus.agu_step, bus.done, bus.beat_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pass;
        set_lengths(1, 0, 3, 5);
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd0; bus.addr_ready = 1'b1;
        #1;
        vectors++;
        if (bus.start_ready !== 1'b1) begin
            miscompares++; $display("FAIL sp_c0_ready: got %b want 1", bus.start_ready);
        end
        @(negedge clk); bus.start = 1'b0; #1;
        vectors++;
        if (bus.agu_clr !== 1'b1 || bus.addr_valid !== 1'b0) begin
            miscompares++; $display("FAIL sp_c1_clr: got clr=%b vld=%b want 1 0", bus.agu_clr, bus.addr_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.addr_valid !== 1'b1 || agu_addr !== 16'd0 || bus.addr_last !== 1'b0 || bus.agu_step !== 1'b1) begin
            miscompares++;
            $display("FAIL sp_c2_beat0: got vld=%b addr=%0d last=%b step=%b want 1 0 0 1",
                     bus.addr_valid, agu_addr, bus.addr_last, bus.agu_step);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.addr_valid !== 1'b1 || agu_addr !== 16'd3 || bus.addr_last !== 1'b1) begin
            miscompares++;
            $display("FAIL sp_c3_beat1: got vld=%b addr=%0d last=%b want 1 3 1", bus.addr_valid, agu_addr, bus.addr_last);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.addr_valid !== 1'b0 || bus.beat_cnt !== 32'd2 || bus.start_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sp_c4_done: got done=%b vld=%b cnt=%0d rdy=%b want 1 0 2 0",
                     bus.done, bus.addr_valid, bus.beat_cnt, bus.start_ready);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.start_ready !== 1'b1 || bus.done !== 1'b0 || bus.beat_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL sp_c5_idle: got rdy=%b done=%b cnt=%0d want 1 0 2", bus.start_ready, bus.done, bus.beat_cnt);
        end
    endtask

    task automatic test_multi_pass;
        int b_beats, b_j4, b_last, b_done, cyc;
        bit seen;
        set_lengths(1, 1, 2, 9);
        b_beats = tot_beats; b_j4 = tot_j4; b_last = tot_last; b_done = tot_done;
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd2; bus.addr_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        wait_done(100, cyc, seen);
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL mp_timeout: no done within 100 cycles");
        end
        repeat (4) @(negedge clk);
        #3;
        vectors++;
        if (tot_beats - b_beats != 12 || bus.beat_cnt !== 32'd12) begin
            miscompares++;
            $display("FAIL mp_beats: got mon=%0d cnt=%0d want 12 12", tot_beats - b_beats, bus.beat_cnt);
        end
        vectors++;
        if (tot_j4 - b_j4 != 3) begin
            miscompares++; $display("FAIL mp_on_j4: got %0d want 3", tot_j4 - b_j4);
        end
        vectors++;
        if (tot_last - b_last != 1 || last_at - b_beats != 12) begin
            miscompares++;
            $display("FAIL mp_last: got count=%0d at_beat=%0d want 1 12", tot_last - b_last, last_at - b_beats);
        end
        vectors++;
        if (tot_done - b_done != 1) begin
            miscompares++; $display("FAIL mp_done_pulses: got %0d want 1", tot_done - b_done);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        bit seen;
        set_lengths(1, 0, 3, 5);
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd0; bus.addr_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.addr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s != 0) @(negedge clk);
            #1;
            vectors++;
            if (bus.addr_valid !== 1'b1 || bus.agu_step !== 1'b0 || agu_addr !== 16'd0) begin
                miscompares++;
                $display("FAIL bp_stall%0d: got vld=%b step=%b addr=%0d want 1 0 0",
                         s, bus.addr_valid, bus.agu_step, agu_addr);
            end
        end
        @(negedge clk); bus.addr_ready = 1'b1; #1;
        vectors++;
        if (agu_addr !== 16'd0 || bus.agu_step !== 1'b1) begin
            miscompares++; $display("FAIL bp_resume: got addr=%0d step=%b want 0 1", agu_addr, bus.agu_step);
        end
        // resume beat is cycle 7; done expected at cycle 9, two cycles later
        wait_done(20, cyc, seen);
        vectors++;
        if (!seen || cyc != 2 || bus.beat_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL bp_latency: got seen=%b cycles=%0d cnt=%0d want 1 2 2", seen, cyc, bus.beat_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int b_clr, b_done, cyc;
        bit seen;
        set_lengths(1, 0, 3, 5);
        b_clr = tot_clr; b_done = tot_done;
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd0; bus.addr_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.reps = 8'd5;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.start_ready !== 1'b0) begin
            miscompares++; $display("FAIL si_done_cycle: got done=%b rdy=%b want 1 0", bus.done, bus.start_ready);
        end
        @(negedge clk); bus.start = 1'b0;
        wait_done(4, cyc, seen);
        #3;
        vectors++;
        if (seen || tot_clr - b_clr != 1 || tot_done - b_done != 1 || bus.beat_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL si_one_job: got extra_done=%b clr=%0d done=%0d cnt=%0d want 0 1 1 2",
                     seen, tot_clr - b_clr, tot_done - b_done, bus.beat_cnt);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        bit seen;
        set_lengths(1, 1, 2, 9);
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd2; bus.addr_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (bus.start_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.agu_step !== 1'b0 ||
            bus.agu_clr !== 1'b0 || bus.done !== 1'b0 || bus.beat_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL ar_immediate: got rdy=%b vld=%b step=%b clr=%b done=%b cnt=%0d want 1 0 0 0 0 0",
                     bus.start_ready, bus.addr_valid, bus.agu_step, bus.agu_clr, bus.done, bus.beat_cnt);
        end
        @(negedge clk); rst = 1'b0;
        set_lengths(1, 0, 3, 5);
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (bus.addr_valid !== 1'b1 || agu_addr !== 16'd0) begin
            miscompares++; $display("FAIL ar_first_addr: got vld=%b addr=%0d want 1 0", bus.addr_valid, agu_addr);
        end
        wait_done(20, cyc, seen);
        vectors++;
        if (!seen || bus.beat_cnt !== 32'd2) begin
            miscompares++; $display("FAIL ar_rerun: got seen=%b cnt=%0d want 1 2", seen, bus.beat_cnt);
        end
        @(negedge clk);
    endtask

`ifdef AGU_SEQ_ABORT_EN
    task automatic test_abort;
        int b_done;
        set_lengths(1, 1, 2, 9);
        b_done = tot_done;
        @(negedge clk);
        bus.start = 1'b1; bus.reps = 8'd2; bus.addr_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); abort = 1'b1; #1;
        vectors++;
        if (bus.addr_valid !== 1'b1 || bus.agu_step !== 1'b0 || bus.addr_last !== 1'b0) begin
            miscompares++;
            $display("FAIL ab_cycle: got vld=%b step=%b last=%b want 1 0 0", bus.addr_valid, bus.agu_step, bus.addr_last);
        end
        @(negedge clk); abort = 1'b0; #1;
        vectors++;
        if (bus.start_ready !== 1'b1 || bus.beat_cnt !== 32'd2 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL ab_after: got rdy=%b cnt=%0d done=%b want 1 2 0", bus.start_ready, bus.beat_cnt, bus.done);
        end
        repeat (3) @(negedge clk);
        #3;
        vectors++;
        if (tot_done != b_done) begin
            miscompares++; $display("FAIL ab_no_done: got %0d done pulses want 0", tot_done - b_done);
        end
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.reps = 8'd0; bus.addr_ready = 1'b0;
`ifdef AGU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        set_lengths(0, 0, 0, 0);
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_backpressure();
        test_start_ignored();
        test_async_reset();
`ifdef AGU_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu_seq.md
Name: agu_seq

Overview:
- Sequencer that drives the address generation unit's clr/step inputs.
- Turns the AGU's free-running address register into a valid/ready address stream.
- Accepts a job start with a pass count, clears the AGU, then issues one step per accepted beat.
- Uses the AGU's on_j4 event to count full nested-loop passes and signals job completion.
- Sits between the MVU control unit and each AGU instance, for both the memory read and memory write paths.

Parameters:
BWREPS, 8, bitwidth of the pass-count field; a job runs reps+1 full passes.
BWBEATS, 32, bitwidth of the per-job beat counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  job request; accepted when start & start_ready
start_ready  output  1  high while in IDLE
reps  input  BWREPS  passes minus one, sampled on start acceptance
addr_valid  output  1  AGU addr_out is a valid beat
addr_ready  input  1  downstream accepts the beat
addr_last  output  1  final beat of the job; qualified by addr_valid & addr_ready
agu_clr  output  1  to AGU clr
agu_step  output  1  to AGU step
agu_on_j4  input  1  from AGU on_j4 (already gated by step)
done  output  1  one-cycle pulse after the last beat is accepted
beat_cnt  output  BWBEATS  beats accepted in the current or most recent job
abort  input  1  present only when AGU_SEQ_ABORT_EN is defined

Behaviour:
- Reset (async, rst=1) sets state=IDLE, rep_cnt=0, beat_cnt=0, done=0.
  - Combinational outputs follow state: start_ready=1, agu_clr=0, agu_step=0, addr_valid=0.
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start: latch rep_cnt<=reps, beat_cnt<=0, go to CLR.
  - start while not in IDLE is ignored; there is no queueing.
- CLR:
  - agu_clr=1 for exactly one cycle, then go to RUN.
  - After this cycle the AGU addr_out=0 and its counters are reloaded.
- RUN:
  - addr_valid=1.
  - agu_step = addr_valid & addr_ready, combinational, so the AGU advances only on an accepted beat.
  - Each accepted beat: beat_cnt <= beat_cnt+1, wrapping modulo 2^BWBEATS.
  - Accepted beat with agu_on_j4=1 (end of a full pass):
    - rep_cnt==0: go to DONE.
    - rep_cnt!=0: rep_cnt <= rep_cnt-1 and stay in RUN. The AGU wraps its own counters; no re-clear.
  - addr_last = agu_step & agu_on_j4 & (rep_cnt==0).
  - addr_ready low holds addr_valid high and agu_step low. Address and counters are frozen indefinitely.
- DONE:
  - done=1 for one cycle, addr_valid=0, then go to IDLE.
  - beat_cnt holds its final value until the next start acceptance.
- Latency:
  - Start accepted at cycle N: agu_clr at N+1, first addr_valid at N+2.
  - Last beat accepted at cycle M: done at M+1, start_ready at M+2.
- Total beats per job = (reps+1)·(l0+1)(l1+1)(l2+1)(l3+1). The AGU lengths are static for the job; the sequencer does not check them.
- reps=0 gives a single pass.
- A single-beat pass (all AGU lengths 0) means agu_on_j4 fires on every beat. The sequencer needs no special case.
- Reset asserted mid-job returns to IDLE immediately. The AGU state is stale until the next CLR, which is harmless.

Optional Feature:
- Macro: AGU_SEQ_ABORT_EN.
- Defined:
  - abort port exists.
  - abort=1 in CLR or RUN forces the next state to IDLE. No done pulse and no addr_last.
  - agu_step is forced 0 in the abort cycle, so no beat is accepted.
  - beat_cnt holds the count of beats accepted before the abort.
  - abort in IDLE or DONE has no effect.
- Not defined: no abort port; jobs always run to completion.

Test Plan:
- Inner loop only, l0=1, l1..l3=0, j0=3, j4=5, reps=0, addr_ready=1:
  - start at cycle 0 -> agu_clr at 1.
  - Beats at cycles 2,3 with addresses 0,3; addr_last on the second beat.
  - done at cycle 4, beat_cnt=2, start_ready=1 at cycle 5.
- Multi-pass, l0=1, l1=1, l2=l3=0, reps=2 -> 12 beats.
  - agu_on_j4 seen 3 times.
  - addr_last only on beat 12, single done pulse, beat_cnt=12.
- Backpressure, same job as the first scenario with addr_ready low for 5 cycles after the first addr_valid:
  - addr_valid stays high, agu_step=0, AGU address holds 0.
  - Job completes 5 cycles later than the first scenario.
- start pulsed during RUN and during DONE -> ignored; exactly one job executes; beat_cnt unaffected.
- rst asserted asynchronously mid-RUN, between clock edges -> outputs immediately show the IDLE values.
  - A new job afterwards starts cleanly: first address 0, correct beat count.
- AGU_SEQ_ABORT_EN defined, abort at the 3rd valid beat of the multi-pass job:
  - No agu_step that cycle, no done, beat_cnt=2.
  - start_ready=1 on the next cycle.
